atan2_port: RTL and testbench
=============================

ATAN2_PORT -- requirements
Module: atan2_port

Interface
REQ-001 Parameter ITER, default 14, number of CORDIC vectoring iterations (legal 8..14).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 service_x  input  1  write strobe for data_x; a sampled write also starts a computation.
REQ-005 service_y  input  1  write strobe for data_y; latches operand only.
REQ-006 data_x  input  16  x (cosine-side) operand, two's complement, 13 fraction bits.
REQ-007 data_y  input  16  y (sine-side) operand, same format as data_x.
REQ-008 data_angle  output  16  atan2(y,x) in radians, two's complement, 3 integer/sign bits, 13 fraction bits.
REQ-009 data_mag  output  16  sqrt(x^2+y^2), unsigned, 13 fraction bits.
REQ-010 de_angle, drw_angle, de_mag, drw_mag  output  1 each  one-cycle result-write strobes, all driven from one register.
REQ-011 busy  output  1  high from the cycle after a start until the cycle after the result strobe.

Function
REQ-012 States IDLE, PRE, ITER, SCALE, DONE; busy = (state != IDLE).
REQ-013 IDLE: service_y high latches data_y; service_x high latches data_x and moves to PRE next edge; both high same edge latch both and start.
REQ-014 service_x/service_y while busy are ignored: operands unchanged, no restart, no queued start.
REQ-015 PRE (1 cycle): sign-extend operands to 19-bit x,y; z=0; if x<0 and y>=0 then (x,y)<-(y,-x), z<=+pi/2; if x<0 and y<0 then (x,y)<-(-y,x), z<=-pi/2.
REQ-016 PRE also sets zero flag when both operands are 0x0000.
REQ-017 ITER: iteration counter i runs 0..ITER-1, one iteration per cycle; y>=0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i); y<0: x-=y>>>i, y+=x>>>i, z-=atan(2^-i); all updates use pre-iteration values.
REQ-018 Arctangent constants are a 14-entry ROM of round(atan(2^-i)*8192), 16-bit; z accumulator is 16-bit and cannot overflow for in-range operands.
REQ-019 SCALE (1 cycle): mag = (x * round(0.607253*2^15)) >> 15, saturated to 0xFFFF; zero flag forces angle 0x0000 and mag 0x0000.
REQ-020 DONE (1 cycle): data_angle and data_mag registers loaded; strobe register high for exactly this cycle; next state IDLE.
REQ-021 Latency: strobes asserted on the (ITER+2)th rising edge after the edge that sampled service_x (16 for default), held one clock.
REQ-022 data_angle/data_mag change only on DONE; held stable between results.
REQ-023 Back-to-back: a service_x sampled in the IDLE cycle right after DONE starts a new computation; no dead cycle required.
REQ-024 Accuracy (ITER=14): angle within +-4 LSB of true atan2; mag within +-4 LSB plus 0.1% for |x|,|y| <= 2.0.
REQ-025 Angle range: y=0, x<0 yields +pi (0x6488 +-4); output never exceeds +-pi by more than 4 LSB.

Reset
REQ-026 reset high: state IDLE, i=0, busy 0, all strobes 0, data_angle 0x0000, data_mag 0x0000, latched operands 0x0000, zero flag 0.
REQ-027 reset during PRE/ITER/SCALE/DONE aborts: no strobe on or after the reset edge, result registers cleared.
REQ-028 reset has priority over service_x/service_y on the same edge; strobes ignored that edge.

Verification
REQ-029 y=0x0000 then x=0x2000 -> one strobe at edge 16, angle 0x0000 +-4, mag 0x2000 +-4, busy low next cycle.
REQ-030 y=0x2000, x=0x0000 -> angle 0x3244 +-4 (pi/2); x=0xE000, y=0x0000 -> angle 0x6488 +-4 (pi), mag 0x2000 +-4.
REQ-031 x=0x2000, y=0xE000 (same edge) -> angle 0xE6DE +-4 (-pi/4), mag 0x2D41 +-8.
REQ-032 x=y=0x0000 -> angle 0x0000, mag 0x0000 exactly, strobe at edge 16.
REQ-033 start, second service_x with new data at edge 5 -> single strobe, first-operand result, no second strobe.
REQ-034 start, reset at edge 8 -> busy 0 and outputs 0x0000 after reset edge, no strobe; fresh start afterwards completes normally.

Source files
------------

// File: rtl/atan2_port.sv
// CORDIC vectoring engine: latches x/y operands, then produces atan2(y,x) and sqrt(x^2+y^2)
// in Q13 after ITER+2 cycles, announced by a one-cycle write strobe.
module atan2_port #(
  parameter int unsigned ITER = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        service_x,
  input  logic        service_y,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  output logic [15:0] data_angle,
  output logic [15:0] data_mag,
  output logic        de_angle,
  output logic        drw_angle,
  output logic        de_mag,
  output logic        drw_mag,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StPre, StIter, StScale, StDone} state_e;

  localparam logic [3:0]         LastIter = 4'(ITER - 1);
  localparam logic signed [15:0] HalfPi   = 16'sd12868;
  // round(0.607253 * 2^15): inverse CORDIC gain
  localparam logic [33:0]        InvGain  = 34'd19898;

  state_e             state_q;
  logic [15:0]        op_x_q, op_y_q;
  logic signed [18:0] x_q, y_q;
  logic signed [15:0] z_q;
  logic [3:0]         i_q;
  logic               zero_q;
  logic [15:0]        angle_q, mag_q;
  logic               stb_q;

  logic signed [18:0] sx, sy, x_sh, y_sh;
  logic signed [15:0] atan_c;
  logic [18:0]        x_pos, mag_full;
  logic [15:0]        mag_sat;

  assign sx   = {{3{op_x_q[15]}}, op_x_q};
  assign sy   = {{3{op_y_q[15]}}, op_y_q};
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  always_comb begin
    atan_c = '0;
    case (i_q)
      4'd0:    atan_c = 16'sd6434;
      4'd1:    atan_c = 16'sd3798;
      4'd2:    atan_c = 16'sd2007;
      4'd3:    atan_c = 16'sd1019;
      4'd4:    atan_c = 16'sd511;
      4'd5:    atan_c = 16'sd256;
      4'd6:    atan_c = 16'sd128;
      4'd7:    atan_c = 16'sd64;
      4'd8:    atan_c = 16'sd32;
      4'd9:    atan_c = 16'sd16;
      4'd10:   atan_c = 16'sd8;
      4'd11:   atan_c = 16'sd4;
      4'd12:   atan_c = 16'sd2;
      4'd13:   atan_c = 16'sd1;
      default: atan_c = 16'sd0;
    endcase
  end

  // x stays non-negative after pre-rotation; clamp defensively before scaling
  assign x_pos    = x_q[18] ? '0 : x_q;
  assign mag_full = 19'(({15'd0, x_pos} * InvGain) >> 15);
  assign mag_sat  = (|mag_full[18:16]) ? 16'hFFFF : mag_full[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_x_q  <= '0;
      op_y_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (service_y) op_y_q <= data_y;
          if (service_x) begin
            op_x_q  <= data_x;
            state_q <= StPre;
          end
        end
        StPre: begin
          zero_q <= (op_x_q == 16'h0000) && (op_y_q == 16'h0000);
          i_q    <= '0;
          // fold left half-plane into the right half so the iterations converge
          if (sx[18] && !sy[18]) begin
            x_q <= sy;
            y_q <= -sx;
            z_q <= HalfPi;
          end else if (sx[18]) begin
            x_q <= -sy;
            y_q <= sx;
            z_q <= -HalfPi;
          end else begin
            x_q <= sx;
            y_q <= sy;
            z_q <= '0;
          end
          state_q <= StIter;
        end
        StIter: begin
          if (!y_q[18]) begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_c;
          end else begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_c;
          end
          if (i_q == LastIter) begin
            i_q     <= '0;
            state_q <= StScale;
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
        StScale: begin
          angle_q <= zero_q ? 16'h0000 : z_q;
          mag_q   <= zero_q ? 16'h0000 : mag_sat;
          stb_q   <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_angle = angle_q;
  assign data_mag   = mag_q;
  assign de_angle   = stb_q;
  assign drw_angle  = stb_q;
  assign de_mag     = stb_q;
  assign drw_mag    = stb_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_atan2_port.sv
// Bench for atan2_port: a real-arithmetic reference checked every cycle, plus directed
// vectors with hand-computed angle/magnitude literals.
module tb_atan2_port;

  localparam int ITER = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        service_x = 1'b0;
  logic        service_y = 1'b0;
  logic [15:0] data_x = '0;
  logic [15:0] data_y = '0;
  logic [15:0] data_angle, data_mag;
  logic        de_angle, drw_angle, de_mag, drw_mag, busy;

  int errors = 0;
  int checks = 0;

  atan2_port #(.ITER(ITER)) dut (
    .clk       (clk),
    .reset     (reset),
    .service_x (service_x),
    .service_y (service_y),
    .data_x    (data_x),
    .data_y    (data_y),
    .data_angle(data_angle),
    .data_mag  (data_mag),
    .de_angle  (de_angle),
    .drw_angle (drw_angle),
    .de_mag    (de_mag),
    .drw_mag   (drw_mag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Difference taken modulo 2^16 so angles near +-pi compare correctly.
  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = int'($signed(16'(act - exp)));
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got 0x%04h, want 0x%04h +-%0d", name, act[15:0], exp[15:0], tol);
    end
  endtask

  // Reference model: transaction-level view of the port.
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_x = '0, m_y = '0;
  int          m_ang = 0, m_mag = 0, m_atol = 0, m_mtol = 0;
  real         rx, ry, ra, rm;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_active = 1'b0; m_k = 0; m_x = '0; m_y = '0;
      m_ang = 0; m_mag = 0; m_atol = 0; m_mtol = 0;
    end else if (!m_active) begin
      if (service_y) m_y = data_y;
      if (service_x) begin
        m_x = data_x;
        m_active = 1'b1;
        m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == ITER + 2) begin
        if (m_x == 16'h0 && m_y == 16'h0) begin
          m_ang = 0; m_mag = 0; m_atol = 0; m_mtol = 0;
        end else begin
          rx = real'($signed(m_x));
          ry = real'($signed(m_y));
          ra = $atan2(ry, rx) * 8192.0;
          m_ang = $rtoi(ra + ((ra >= 0.0) ? 0.5 : -0.5));
          rm = $sqrt(rx * rx + ry * ry);
          m_mag = $rtoi(rm + 0.5);
          if (m_mag > 65535) m_mag = 65535;
          m_atol = 4;
          m_mtol = 4 + $rtoi(rm / 1000.0) + 1;
        end
      end else if (m_k == ITER + 3) begin
        m_active = 1'b0;
      end
    end
    check("busy", int'(busy), int'(m_active), 0);
    check("strobes", int'({de_angle, drw_angle, de_mag, drw_mag}),
          (m_active && m_k == ITER + 2) ? 15 : 0, 0);
    check("angle", int'(data_angle), m_ang, m_atol);
    check("mag", int'(data_mag), m_mag, m_mtol);
  end

  task automatic write_y(input logic [15:0] y);
    @(negedge clk);
    data_y = y; service_y = 1'b1;
    @(negedge clk);
    service_y = 1'b0;
  endtask

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input bit wy);
    @(negedge clk);
    data_x = x; data_y = y; service_x = 1'b1; service_y = wy;
    @(negedge clk);
    service_x = 1'b0; service_y = 1'b0;
  endtask

  // Counts edges from the one after the call; a timeout shows up as a latency mismatch.
  task automatic wait_strobe(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!de_angle && n < max);
  endtask

  task automatic run_lit(input string name, input logic [15:0] x, input logic [15:0] y,
                         input bit wy, input int ea, input int em, input int tm);
    int n;
    start_op(x, y, wy);
    wait_strobe(40, n);
    check({name, "_latency"}, n, ITER + 2, 0);
    check({name, "_angle"}, int'(data_angle), ea, 4);
    check({name, "_mag"}, int'(data_mag), em, tm);
    @(posedge clk); #1;
    check({name, "_busy_after"}, int'(busy), 0, 0);
  endtask

  task automatic run_model(input logic [15:0] x, input logic [15:0] y);
    int n;
    start_op(x, y, 1'b1);
    wait_strobe(40, n);
    check("vec_latency", n, ITER + 2, 0);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0, 0);
    check("reset_angle", int'(data_angle), 0, 0);
    check("reset_mag", int'(data_mag), 0, 0);
    reset = 1'b0;

    write_y(16'h0000);
    run_lit("x1y0", 16'h2000, 16'h0000, 1'b0, 16'h0000, 16'h2000, 4);
    write_y(16'h2000);
    run_lit("x0y1", 16'h0000, 16'h0000, 1'b0, 16'h3244, 16'h2000, 4);
    write_y(16'h0000);
    run_lit("xm1y0", 16'hE000, 16'h0000, 1'b0, 16'h6488, 16'h2000, 4);
    run_lit("x1ym1", 16'h2000, 16'hE000, 1'b1, 16'hE6DE, 16'h2D41, 8);
    run_lit("zero", 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 0);

    // Writes while busy are ignored
    start_op(16'h1000, 16'h1000, 1'b1);
    repeat (4) @(negedge clk);
    data_x = 16'hE000; data_y = 16'h2000; service_x = 1'b1; service_y = 1'b1;
    @(negedge clk);
    service_x = 1'b0; service_y = 1'b0;
    wait_strobe(40, n);
    check("ignore_latency", n, ITER + 2 - 5, 0);
    check("ignore_angle", int'(data_angle), 16'h1922, 4);
    check("ignore_mag", int'(data_mag), 16'h16A1, 10);
    repeat (40) @(posedge clk);

    // Back-to-back start in the idle cycle right after DONE
    start_op(16'h3000, 16'h1000, 1'b1);
    wait_strobe(40, n);
    check("b2b_first_latency", n, ITER + 2, 0);
    @(posedge clk); #1;
    check("b2b_idle", int'(busy), 0, 0);
    start_op(16'hF000, 16'h1800, 1'b1);
    wait_strobe(40, n);
    check("b2b_second_latency", n, ITER + 2, 0);
    @(posedge clk);

    // Abort by reset at edge 8, with a competing start on the same edge
    start_op(16'h2000, 16'h1000, 1'b1);
    repeat (7) @(negedge clk);
    reset = 1'b1; data_x = 16'h1000; data_y = 16'h7000; service_x = 1'b1; service_y = 1'b1;
    @(negedge clk);
    reset = 1'b0; service_x = 1'b0; service_y = 1'b0;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_angle", int'(data_angle), 0, 0);
    check("abort_mag", int'(data_mag), 0, 0);
    check("abort_strobe", int'(de_angle), 0, 0);
    repeat (30) @(posedge clk);
    // y latch was cleared by reset, so only x contributes
    run_lit("after_abort", 16'h2000, 16'h5555, 1'b0, 16'h0000, 16'h2000, 4);

    run_model(16'hE000, 16'hE000);
    run_model(16'h4000, 16'hC000);
    run_model(16'hC000, 16'h0001);
    run_model(16'hC000, 16'hFFFF);
    run_model(16'h0800, 16'hF800);
    run_model(16'hD000, 16'h3800);

    repeat (5) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
